// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, default oversampling factor and width helper.
package uart_pkg;
  localparam int NUM_TICKS_DEF = 16;
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with parameterized reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; define UART_RX_PARITY_EN to add the even-parity bit and checker.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NUM_TICKS     = NUM_TICKS_DEF,
  parameter int BITS_PER_DATA = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     rx_in,
  input  logic                     parity,
  input  logic [1:0]               stop_bits,
  output logic [BITS_PER_DATA-1:0] d_out,
  output logic                     rx_done,
  output logic                     parity_err,
  output logic                     frame_err
);
  localparam int SW = clog2(NUM_TICKS);
  localparam int NW = clog2(BITS_PER_DATA + 1);
  localparam logic [SW-1:0] S_MID = SW'(NUM_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(NUM_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(BITS_PER_DATA - 1);
  logic rx;
  state_t state, state_d;
  logic [SW-1:0] s, s_d;
  logic [NW-1:0] n, n_d;
  logic [1:0] k, k_d, sb, sb_d;
  logic [BITS_PER_DATA-1:0] sh, sh_d, d_d;
  logic fe, fe_d, done_d, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, pe, pe_d, perr_d;
`else
  logic unused_parity;
  assign unused_parity = parity;
  assign parity_err = 1'b0;
`endif
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rx_in), .q(rx));
  always_comb begin
    state_d = state;
    s_d = s;
    n_d = n;
    k_d = k;
    sb_d = sb;
    sh_d = sh;
    fe_d = fe;
    d_d = d_out;
    done_d = 1'b0;
    ferr_d = frame_err;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    pe_d = pe;
    perr_d = parity_err;
`endif
    case (state)
      IDLE: if (tick && !rx) begin
        state_d = START;
        s_d = '0;
        sb_d = (stop_bits == 2'd0) ? 2'd1 : stop_bits;
        fe_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d = parity;
        pe_d = 1'b0;
`endif
      end
      START: if (tick) begin
        s_d = (s == S_MID) ? '0 : s + 1'b1;
        n_d = '0;
        if (s == S_MID) state_d = rx ? IDLE : DATA;
      end
      DATA: if (tick) begin
        s_d = (s == S_END) ? '0 : s + 1'b1;
        if (s == S_END) begin
          sh_d = {rx, sh[BITS_PER_DATA-1:1]};
          n_d = n + 1'b1;
          k_d = '0;
          if (n == N_LAST)
`ifdef UART_RX_PARITY_EN
            state_d = par_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        s_d = (s == S_END) ? '0 : s + 1'b1;
        if (s == S_END) begin
          pe_d = rx ^ (^sh);
          state_d = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        s_d = (s == S_END) ? '0 : s + 1'b1;
        if (s == S_END) begin
          k_d = k + 2'd1;
          fe_d = fe | ~rx;
          if (k == sb - 2'd1) begin
            state_d = IDLE;
            d_d = sh;
            done_d = 1'b1;
            ferr_d = fe | ~rx;
`ifdef UART_RX_PARITY_EN
            perr_d = pe;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      k <= '0;
      sb <= 2'd1;
      sh <= '0;
      fe <= 1'b0;
      d_out <= '0;
      rx_done <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      pe <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_d;
      s <= s_d;
      n <= n_d;
      k <= k_d;
      sb <= sb_d;
      sh <= sh_d;
      fe <= fe_d;
      d_out <= d_d;
      rx_done <= done_d;
      frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      pe <= pe_d;
      parity_err <= perr_d;
`endif
    end
endmodule
